// File: rtl/enemy_controller.sv
// Life-cycle sequencer for one enemy: spawn, draw, wait frames, erase, move, bottom check.
// Shares a plotter via drawReq/drawDone; tracks escapes/kills and raises fall speed per level.
module enemy_controller #(
  parameter int unsigned FRAMES_PER_MOVE = 4,
  parameter int unsigned ESC_PER_LEVEL   = 5,
  parameter int unsigned MAX_SPEED       = 7,
  parameter int unsigned INIT_SPEED      = 1,
  parameter int unsigned X_START         = 8,
  parameter int unsigned X_STEP          = 37,
  parameter int unsigned X_MAX           = 150
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       start,
  input  logic       frameTick,
  input  logic       bottomReached,
  input  logic       hit,
  input  logic       drawDone,
  output logic       drawReq,
  output logic       erase,
  output logic       inResetState,
  output logic       inUpdatePositionState,
  output logic [7:0] enemyXIn,
  output logic [2:0] speed,
  output logic [7:0] escapes,
  output logic [7:0] kills
);

  localparam int unsigned FW = $clog2(FRAMES_PER_MOVE + 1);
  localparam int unsigned LW = $clog2(ESC_PER_LEVEL + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SPAWN,
    ST_DRAW,
    ST_WAIT,
    ST_ERASE,
    ST_UPDATE,
    ST_CHECK
  } state_t;

  state_t          state_q, state_d;
  logic [FW-1:0]   frame_q, frame_d;
  logic [LW-1:0]   level_q, level_d;
  logic            killed_q, killed_d;
  logic [7:0]      x_q, x_d;
  logic [2:0]      speed_q, speed_d;
  logic [7:0]      esc_q, esc_d;
  logic [7:0]      kill_q, kill_d;
  logic [8:0]      x_sum;
  logic [7:0]      x_adv;

  // Respawn X wraps back into [0, X_MAX]; the sum is 9 bits so it cannot overflow.
  always_comb begin
    x_sum = {1'b0, x_q} + 9'(X_STEP);
    x_adv = 8'((x_sum > 9'(X_MAX)) ? (x_sum - 9'(X_MAX + 1)) : x_sum);
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q  <= ST_IDLE;
      frame_q  <= '0;
      level_q  <= '0;
      killed_q <= 1'b0;
      x_q      <= 8'(X_START);
      speed_q  <= 3'(INIT_SPEED);
      esc_q    <= '0;
      kill_q   <= '0;
    end else begin
      state_q  <= state_d;
      frame_q  <= frame_d;
      level_q  <= level_d;
      killed_q <= killed_d;
      x_q      <= x_d;
      speed_q  <= speed_d;
      esc_q    <= esc_d;
      kill_q   <= kill_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    level_d  = level_q;
    killed_d = killed_q;
    x_d      = x_q;
    speed_d  = speed_q;
    esc_d    = esc_q;
    kill_d   = kill_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_SPAWN;
      end
      ST_SPAWN: begin
        state_d = ST_DRAW;
      end
      ST_DRAW: begin
        if (drawDone) begin
          frame_d = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // hit wins over a coincident frameTick
        if (hit) begin
          killed_d = 1'b1;
          state_d  = ST_ERASE;
        end else if (frameTick) begin
          if (frame_q == FW'(FRAMES_PER_MOVE - 1)) begin
            frame_d  = FW'(FRAMES_PER_MOVE);
            killed_d = 1'b0;
            state_d  = ST_ERASE;
          end else begin
            frame_d = frame_q + FW'(1);
          end
        end
      end
      ST_ERASE: begin
        if (drawDone) begin
          if (killed_q) begin
            if (kill_q != 8'hFF) kill_d = kill_q + 8'd1;
            x_d     = x_adv;
            state_d = ST_SPAWN;
          end else begin
            state_d = ST_UPDATE;
          end
        end
      end
      ST_UPDATE: begin
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (bottomReached) begin
          if (esc_q != 8'hFF) esc_d = esc_q + 8'd1;
          if (level_q == LW'(ESC_PER_LEVEL - 1)) begin
            level_d = '0;
            if (speed_q < 3'(MAX_SPEED)) speed_d = speed_q + 3'd1;
          end else begin
            level_d = level_q + LW'(1);
          end
          x_d     = x_adv;
          state_d = ST_SPAWN;
        end else begin
          state_d = ST_DRAW;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes decode directly from the state register so reset clears them asynchronously.
  assign drawReq               = (state_q == ST_DRAW) || (state_q == ST_ERASE);
  assign erase                 = (state_q == ST_ERASE);
  assign inResetState          = (state_q == ST_SPAWN);
  assign inUpdatePositionState = (state_q == ST_UPDATE);
  assign enemyXIn              = x_q;
  assign speed                 = speed_q;
  assign escapes               = esc_q;
  assign kills                 = kill_q;

endmodule

// File: tb/tb_enemy_controller.sv
// Scoreboard bench for enemy_controller: driver queues expected strobe events,
// a negedge monitor pops and compares each spawn, update and plot request.
module tb_enemy_controller;

  logic       clk = 1'b0;
  logic       n_reset;
  logic       start, frameTick, bottomReached, hit, drawDone;
  logic       drawReq, erase, inResetState, inUpdatePositionState;
  logic [7:0] enemyXIn, escapes, kills;
  logic [2:0] speed;

  enemy_controller #(
    .FRAMES_PER_MOVE(4),
    .ESC_PER_LEVEL  (5),
    .MAX_SPEED      (7),
    .INIT_SPEED     (1),
    .X_START        (8),
    .X_STEP         (37),
    .X_MAX          (150)
  ) dut (
    .clk                  (clk),
    .n_reset              (n_reset),
    .start                (start),
    .frameTick            (frameTick),
    .bottomReached        (bottomReached),
    .hit                  (hit),
    .drawDone             (drawDone),
    .drawReq              (drawReq),
    .erase                (erase),
    .inResetState         (inResetState),
    .inUpdatePositionState(inUpdatePositionState),
    .enemyXIn             (enemyXIn),
    .speed                (speed),
    .escapes              (escapes),
    .kills                (kills)
  );

  always #5 clk = ~clk;

  typedef enum int {EV_SPAWN, EV_UPDATE, EV_REQ} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       x;
    int       spd;
    int       esc;
    int       kil;
    int       er;
  } ev_t;

  ev_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  // Reference model state
  int m_x, m_speed, m_esc, m_kills, m_lvl;

  function automatic int next_x(input int x);
    int nx;
    nx = x + 37;
    return (nx > 150) ? nx - 151 : nx;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic push(input ev_kind_t k, input int er);
    ev_t e;
    e.kind = k; e.x = m_x; e.spd = m_speed; e.esc = m_esc; e.kil = m_kills; e.er = er;
    exp_q.push_back(e);
  endtask

  // Monitor: every observed event must match the head of the queue
  logic req_prev = 1'b0;

  task automatic check_evt(input ev_kind_t k);
    ev_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d with empty queue at %0t", k, $time);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != k) begin
      n_fail++;
      $display("FAIL event_kind: got %0d expected %0d at %0t", k, e.kind, $time);
    end else if (k == EV_SPAWN &&
                 (enemyXIn != e.x || speed != e.spd || escapes != e.esc || kills != e.kil)) begin
      n_fail++;
      $display("FAIL spawn_fields: got x=%0d spd=%0d esc=%0d kil=%0d expected x=%0d spd=%0d esc=%0d kil=%0d",
               enemyXIn, speed, escapes, kills, e.x, e.spd, e.esc, e.kil);
    end else if (k == EV_REQ && erase != e.er[0]) begin
      n_fail++;
      $display("FAIL req_erase: got %0d expected %0d at %0t", erase, e.er, $time);
    end
  endtask

  always @(negedge clk) begin
    if (n_reset) begin
      if (inResetState)             check_evt(EV_SPAWN);
      if (inUpdatePositionState)    check_evt(EV_UPDATE);
      if (drawReq && !req_prev)     check_evt(EV_REQ);
      req_prev <= drawReq;
    end else begin
      req_prev <= 1'b0;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_req();
    for (int i = 0; i < 100; i++) begin
      if (drawReq) break;
      tick();
    end
    if (!drawReq) chk("drawreq_timeout", 0, 1);
  endtask

  task automatic pulse_done();
    drawDone = 1'b1;
    tick();
    drawDone = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frameTick = 1'b1;
      tick();
      frameTick = 1'b0;
      tick();
    end
  endtask

  // Starts and ends in WAIT
  task automatic move(input bit bottom);
    push(EV_REQ, 1);
    frames(4);
    bottomReached = bottom;
    wait_req();
    push(EV_UPDATE, 0);
    if (bottom) begin
      if (m_esc < 255) m_esc++;
      m_lvl++;
      if (m_lvl == 5) begin
        m_lvl = 0;
        if (m_speed < 7) m_speed++;
      end
      m_x = next_x(m_x);
      push(EV_SPAWN, 0);
    end
    push(EV_REQ, 0);
    pulse_done();
    tick();
    tick();
    bottomReached = 1'b0;
    wait_req();
    pulse_done();
  endtask

  task automatic kill_now();
    push(EV_REQ, 1);
    if (m_kills < 255) m_kills++;
    m_x = next_x(m_x);
    push(EV_SPAWN, 0);
    push(EV_REQ, 0);
    hit = 1'b1;
    frameTick = 1'b1;
    tick();
    hit = 1'b0;
    frameTick = 1'b0;
    wait_req();
    pulse_done();
    wait_req();
    pulse_done();
  endtask

  initial begin
    bit held;
    n_reset = 1'b0;
    start = 0; frameTick = 0; bottomReached = 0; hit = 0; drawDone = 0;
    m_x = 8; m_speed = 1; m_esc = 0; m_kills = 0; m_lvl = 0;
    repeat (3) tick();
    chk("rst_drawReq", drawReq, 0);
    chk("rst_inReset", inResetState, 0);
    chk("rst_inUpdate", inUpdatePositionState, 0);
    chk("rst_erase", erase, 0);
    chk("rst_speed", speed, 1);
    chk("rst_x", enemyXIn, 8);
    chk("rst_escapes", escapes, 0);
    chk("rst_kills", kills, 0);
    #3 n_reset = 1'b1;
    tick();
    tick();
    chk("idle_quiet", inResetState, 0);

    push(EV_SPAWN, 0);
    push(EV_REQ, 0);
    start = 1'b1;
    tick();
    chk("start_latency", inResetState, 1);
    wait_req();
    // drawReq must hold without drawDone; stray hit/frameTick are ignored
    held = 1'b1;
    for (int i = 0; i < 20; i++) begin
      hit       = (i == 5);
      frameTick = (i == 5) || (i == 10);
      tick();
      if (!drawReq || erase) held = 1'b0;
    end
    hit = 0; frameTick = 0;
    chk("draw_hold", held, 1);
    pulse_done();

    move(1'b0);
    frames(2);
    kill_now();
    chk("kill_count", kills, 1);
    chk("kill_x", enemyXIn, 45);

    for (int i = 1; i <= 257; i++) begin
      move(1'b1);
      if (i == 3)   chk("wrap_x", enemyXIn, 5);
      if (i == 5)   begin chk("esc5_escapes", escapes, 5); chk("esc5_speed", speed, 2); end
      if (i == 35)  chk("esc35_speed", speed, 7);
      if (i == 40)  chk("esc40_speed", speed, 7);
      if (i == 257) chk("esc_saturate", escapes, 255);
    end
    move(1'b0);
    repeat (3) tick();
    chk("queue_drained", exp_q.size(), 0);

    // Reset in the middle of an erase handshake
    push(EV_REQ, 1);
    frames(4);
    wait_req();
    start = 1'b0;
    #2 n_reset = 1'b0;
    #1;
    chk("mid_rst_drawReq", drawReq, 0);
    chk("mid_rst_escapes", escapes, 0);
    chk("mid_rst_kills", kills, 0);
    chk("mid_rst_speed", speed, 1);
    chk("mid_rst_x", enemyXIn, 8);
    chk("mid_rst_queue", exp_q.size(), 0);
    tick();
    #3 n_reset = 1'b1;
    repeat (5) tick();
    chk("post_rst_idle", inResetState, 0);
    m_x = 8; m_speed = 1; m_esc = 0; m_kills = 0; m_lvl = 0;
    push(EV_SPAWN, 0);
    push(EV_REQ, 0);
    start = 1'b1;
    tick();
    wait_req();
    repeat (3) tick();
    chk("final_queue", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
